// File: rtl/match_sequencer_pkg.sv
// match_sequencer_pkg: shared gamestate and winner encodings for the round scheduler
package match_sequencer_pkg;
  typedef enum logic [2:0] {
    GS_IDLE      = 3'd0,
    GS_COUNTDOWN = 3'd1,
    GS_PLAY      = 3'd2,
    GS_GOAL      = 3'd3,
    GS_OVER      = 3'd4
  } gamestate_t;
  typedef enum logic [1:0] {
    WIN_NONE  = 2'd0,
    WIN_LEFT  = 2'd1,
    WIN_RIGHT = 2'd2,
    WIN_DRAW  = 2'd3
  } winner_t;
endpackage

// File: rtl/match_sequencer_sec_downcounter.sv
// sec_downcounter: loadable per-second down counter that holds at zero, load beats tick
module sec_downcounter #(
  parameter int W = 7,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         FPGA_clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] value,
  output logic         zero
);
  always_ff @(posedge FPGA_clk)
    if (reset) value <= RST_VAL;
    else if (load) value <= load_val;
    else if (tick && value != '0) value <= value - 1'b1;
  assign zero = value == '0;
endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: air-hockey round scheduler owning phases, scores, serves and the time display
module match_sequencer #(
  parameter int COUNTDOWN_S = 5,
  parameter int MATCH_S     = 99,
  parameter int PAUSE_S     = 2,
  parameter int WIN_SCORE   = 7,
  parameter int SW          = 7
) (
  input  logic          FPGA_clk,
  input  logic          reset,
  input  logic          start,
  input  logic          sec_tick,
  input  logic          goal_l,
  input  logic          goal_r,
  output logic [2:0]    gamestate,
  output logic          ball_run,
  output logic          serve,
  output logic          serve_dir,
  output logic [SW-1:0] lscore,
  output logic [SW-1:0] rscore,
  output logic [SW-1:0] timecount,
  output logic [1:0]    winner
);
  import match_sequencer_pkg::*;
  localparam logic [SW-1:0] CD = SW'(COUNTDOWN_S);
  localparam logic [SW-1:0] MS = SW'(MATCH_S);
  localparam logic [SW-1:0] PS = SW'(PAUSE_S);
  localparam logic [SW-1:0] WS = SW'(WIN_SCORE);
  localparam logic [SW-1:0] SMAX = '1;
  gamestate_t gs, gs_n;
  logic t_zero, p_zero, t_load, t_tick, p_load, p_tick;
  logic launch, gl, gr, hit_win;
  logic ball_run_n, serve_n, serve_dir_n;
  logic [1:0] winner_n;
  logic [SW-1:0] t_val, ls_n, rs_n, pause_unused;
  assign launch  = start && (gs == GS_IDLE || gs == GS_OVER);
  assign gl      = goal_l && gs == GS_PLAY;
  assign gr      = goal_r && !goal_l && gs == GS_PLAY;
  assign ls_n    = launch ? '0 : (gl && lscore != SMAX) ? lscore + 1'b1 : lscore;
  assign rs_n    = launch ? '0 : (gr && rscore != SMAX) ? rscore + 1'b1 : rscore;
  assign hit_win = (gl && ls_n == WS) || (gr && rs_n == WS);
  assign t_load  = launch || (gs == GS_COUNTDOWN && sec_tick && t_zero);
  assign t_val   = launch ? CD : MS;
  assign t_tick  = sec_tick && (gs == GS_COUNTDOWN || gs == GS_PLAY);
  assign p_load  = gs == GS_PLAY && gs_n == GS_GOAL;
  assign p_tick  = sec_tick && gs == GS_GOAL;
  sec_downcounter #(.W(SW), .RST_VAL(CD)) u_time (
    .FPGA_clk(FPGA_clk), .reset(reset), .load(t_load), .load_val(t_val),
    .tick(t_tick), .value(timecount), .zero(t_zero)
  );
  sec_downcounter #(.W(SW), .RST_VAL(PS)) u_pause (
    .FPGA_clk(FPGA_clk), .reset(reset), .load(p_load), .load_val(PS),
    .tick(p_tick), .value(pause_unused), .zero(p_zero)
  );
  always_ff @(posedge FPGA_clk)
    if (reset) begin
      gs        <= GS_IDLE;
      ball_run  <= 1'b0;
      serve     <= 1'b0;
      serve_dir <= 1'b1;
      lscore    <= '0;
      rscore    <= '0;
      winner    <= WIN_NONE;
    end else begin
      gs        <= gs_n;
      ball_run  <= ball_run_n;
      serve     <= serve_n;
      serve_dir <= serve_dir_n;
      lscore    <= ls_n;
      rscore    <= rs_n;
      winner    <= winner_n;
    end
  always_comb begin
    gs_n = gs;
    case (gs)
      GS_IDLE, GS_OVER: gs_n = start ? GS_COUNTDOWN : gs;
      GS_COUNTDOWN:     gs_n = (sec_tick && t_zero) ? GS_PLAY : gs;
      // a goal that lands with the expiring tick still counts, then the match ends
      GS_PLAY:          gs_n = (hit_win || (sec_tick && t_zero)) ? GS_OVER : (gl || gr) ? GS_GOAL : GS_PLAY;
      GS_GOAL:          gs_n = (sec_tick && p_zero) ? GS_PLAY : gs;
      default:          gs_n = GS_IDLE;
    endcase
  end
  always_comb begin
    ball_run_n  = gs_n == GS_PLAY;
    serve_n     = (gs == GS_COUNTDOWN || gs == GS_GOAL) && gs_n == GS_PLAY;
    serve_dir_n = gl ? 1'b0 : gr ? 1'b1 : (gs == GS_COUNTDOWN && gs_n == GS_PLAY) ? 1'b1 : serve_dir;
    winner_n    = launch ? WIN_NONE
                : (gs == GS_PLAY && gs_n == GS_OVER)
                  ? ((ls_n > rs_n) ? WIN_LEFT : (rs_n > ls_n) ? WIN_RIGHT : WIN_DRAW)
                : winner;
  end
  assign gamestate = gs;
endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed stimulus with a per-cycle behavioural model and literal checkpoints
module tb_match_sequencer;
  logic FPGA_clk, reset, start, sec_tick, goal_l, goal_r;
  logic [2:0] gamestate;
  logic ball_run, serve, serve_dir;
  logic [6:0] lscore, rscore, timecount;
  logic [1:0] winner;
  int errors = 0, checks = 0;
  bit chk_en = 0;
  int m_gs = 0, m_t = 5, m_p = 2, m_l = 0, m_r = 0, m_win = 0;
  bit m_run = 0, m_serve = 0, m_dir = 1;
  match_sequencer dut (
    .FPGA_clk(FPGA_clk), .reset(reset), .start(start), .sec_tick(sec_tick),
    .goal_l(goal_l), .goal_r(goal_r), .gamestate(gamestate), .ball_run(ball_run),
    .serve(serve), .serve_dir(serve_dir), .lscore(lscore), .rscore(rscore),
    .timecount(timecount), .winner(winner)
  );
  initial FPGA_clk = 0;
  always #5 FPGA_clk = ~FPGA_clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(posedge FPGA_clk) begin
    bit scored, expire;
    if (reset) begin
      m_gs = 0; m_t = 5; m_p = 2; m_l = 0; m_r = 0; m_win = 0;
      m_run = 0; m_serve = 0; m_dir = 1;
    end else begin
      m_serve = 0;
      case (m_gs)
        0, 4: if (start) begin
          m_gs = 1; m_t = 5; m_l = 0; m_r = 0; m_win = 0;
        end
        1: if (sec_tick) begin
          if (m_t == 0) begin
            m_gs = 2; m_t = 99; m_serve = 1; m_dir = 1;
          end else m_t--;
        end
        2: begin
          scored = 0;
          expire = sec_tick && m_t == 0;
          if (sec_tick && m_t > 0) m_t--;
          if (goal_l) begin
            m_l = (m_l < 127) ? m_l + 1 : 127; m_dir = 0; scored = 1;
          end else if (goal_r) begin
            m_r = (m_r < 127) ? m_r + 1 : 127; m_dir = 1; scored = 1;
          end
          if ((scored && (m_l == 7 || m_r == 7)) || expire) begin
            m_gs = 4;
            m_win = (m_l > m_r) ? 1 : (m_r > m_l) ? 2 : 3;
          end else if (scored) begin
            m_gs = 3; m_p = 2;
          end
        end
        3: if (sec_tick) begin
          if (m_p == 0) begin
            m_gs = 2; m_serve = 1;
          end else m_p--;
        end
        default: m_gs = 0;
      endcase
      m_run = m_gs == 2;
    end
  end
  always @(negedge FPGA_clk)
    if (chk_en) begin
      chk("cyc gamestate", int'(gamestate), m_gs);
      chk("cyc ball_run", int'(ball_run), int'(m_run));
      chk("cyc serve", int'(serve), int'(m_serve));
      chk("cyc serve_dir", int'(serve_dir), int'(m_dir));
      chk("cyc lscore", int'(lscore), m_l);
      chk("cyc rscore", int'(rscore), m_r);
      chk("cyc timecount", int'(timecount), m_t);
      chk("cyc winner", int'(winner), m_win);
    end
  task automatic cyc(input bit st, input bit tk, input bit l, input bit r);
    @(negedge FPGA_clk);
    start = st; sec_tick = tk; goal_l = l; goal_r = r;
    @(posedge FPGA_clk);
    #1;
    start = 0; sec_tick = 0; goal_l = 0; goal_r = 0;
  endtask
  task automatic ticks(input int n);
    repeat (n) cyc(0, 1, 0, 0);
  endtask
  initial begin
    reset = 1; start = 0; sec_tick = 0; goal_l = 0; goal_r = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_en = 1;
    reset = 0;
    chk("rst gamestate", int'(gamestate), 0);
    chk("rst timecount", int'(timecount), 5);
    chk("rst serve_dir", int'(serve_dir), 1);
    cyc(1, 0, 0, 0);
    chk("start countdown", int'(gamestate), 1);
    cyc(0, 0, 1, 0);
    chk("goal in countdown", int'(lscore), 0);
    for (int i = 0; i < 5; i++) begin
      ticks(1);
      chk("countdown value", int'(timecount), 4 - i);
    end
    ticks(1);
    chk("play entry state", int'(gamestate), 2);
    chk("play entry time", int'(timecount), 99);
    chk("play entry serve", int'(serve), 1);
    chk("play entry run", int'(ball_run), 1);
    cyc(0, 0, 0, 0);
    chk("serve one cycle", int'(serve), 0);
    cyc(0, 0, 0, 1);
    chk("goal_r rscore", int'(rscore), 1);
    chk("goal_r state", int'(gamestate), 3);
    chk("goal_r run", int'(ball_run), 0);
    ticks(2);
    chk("pause still goal", int'(gamestate), 3);
    ticks(1);
    chk("reserve state", int'(gamestate), 2);
    chk("reserve serve", int'(serve), 1);
    chk("reserve dir", int'(serve_dir), 1);
    chk("time frozen", int'(timecount), 99);
    cyc(0, 0, 1, 1);
    chk("both goals lscore", int'(lscore), 1);
    chk("both goals rscore", int'(rscore), 1);
    chk("both goals dir", int'(serve_dir), 0);
    ticks(3);
    cyc(0, 0, 1, 0);
    ticks(3);
    cyc(0, 0, 0, 1);
    ticks(3);
    ticks(99);
    chk("time at zero state", int'(gamestate), 2);
    chk("time at zero", int'(timecount), 0);
    ticks(1);
    chk("timeout state", int'(gamestate), 4);
    chk("timeout winner", int'(winner), 3);
    chk("timeout run", int'(ball_run), 0);
    cyc(0, 0, 1, 0);
    chk("over goal ignored", int'(lscore), 2);
    cyc(1, 0, 0, 0);
    chk("restart scores", int'(lscore) + int'(rscore), 0);
    chk("restart winner", int'(winner), 0);
    ticks(6);
    for (int g = 0; g < 7; g++) begin
      cyc(0, 0, 1, 0);
      if (g < 6) ticks(3);
    end
    chk("seven goals state", int'(gamestate), 4);
    chk("seven goals lscore", int'(lscore), 7);
    chk("seven goals winner", int'(winner), 1);
    chk("seven goals run", int'(ball_run), 0);
    cyc(1, 0, 0, 0);
    ticks(6);
    cyc(0, 0, 0, 1);
    ticks(1);
    chk("mid goal state", int'(gamestate), 3);
    reset = 1;
    cyc(0, 1, 0, 0);
    reset = 0;
    chk("reset gamestate", int'(gamestate), 0);
    chk("reset rscore", int'(rscore), 0);
    chk("reset timecount", int'(timecount), 5);
    chk("reset serve_dir", int'(serve_dir), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
